// File: rtl/shared_buffer_slot_allocator_pkg.sv
// Shared constants and helpers for the shared-buffer slot allocator.
package shared_buffer_slot_allocator_pkg;

    // Ceiling log2 with a floor of 1 so that single-entry ranges still get a bit.
    function automatic int clogb(input int value);
        int w;
        w = 1;
        while ((32'(1) << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Width of a slot index for a buffer of the given depth.
    function automatic int slot_addr_width(input int depth);
        return clogb(depth);
    endfunction

    // Width of a virtual-channel index.
    function automatic int vc_idx_width_of(input int num_vcs);
        return clogb(num_vcs);
    endfunction

    // The guaranteed reservations must fit inside the physical buffer.
    function automatic bit reservation_ok(input int depth, input int num_vcs, input int reserved);
        return (num_vcs * reserved) <= depth;
    endfunction

endpackage

// File: rtl/shared_buffer_slot_allocator_free_slot_fifo.sv
// Circular list of free slot indices; resets holding every slot in ascending order.
module shared_buffer_slot_allocator_free_slot_fifo
    import shared_buffer_slot_allocator_pkg::*;
#(
    parameter int depth       = 32,
    parameter int addr_width  = 5,
    parameter int count_width = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pop,
    input  logic                   push,
    input  logic [addr_width-1:0]  push_slot,
    output logic [addr_width-1:0]  head_slot,
    output logic [count_width-1:0] count
);

    logic [addr_width-1:0]  slots [depth];
    logic [addr_width-1:0]  head;
    logic [addr_width-1:0]  tail;
    logic [count_width-1:0] count_q;

    // Pointers wrap at depth rather than at a power of two.
    function automatic logic [addr_width-1:0] wrap_inc(input logic [addr_width-1:0] ptr);
        return (ptr == addr_width'(depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Slot storage: reset seeds 0..depth-1, pushes write at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                slots[i] <= addr_width'(i);
            end
        end else if (push) begin
            slots[tail] <= push_slot;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= count_width'(depth);
        end else begin
            if (pop) begin
                head <= wrap_inc(head);
            end
            if (push) begin
                tail <= wrap_inc(tail);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_slot = slots[head];
    assign count     = count_q;

endmodule

// File: rtl/shared_buffer_slot_allocator.sv
// Free-slot manager for a shared input buffer with per-VC reservations and a shared pool.
module shared_buffer_slot_allocator
    import shared_buffer_slot_allocator_pkg::*;
#(
    parameter int memory_bank_depth   = 32,
    parameter int num_vcs             = 4,
    parameter int reserved_per_vc     = 2,
    localparam int memory_addr_width  = slot_addr_width(memory_bank_depth),
    localparam int vc_idx_width       = vc_idx_width_of(num_vcs),
    localparam int count_width        = clogb(memory_bank_depth + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_req,
    input  logic [vc_idx_width-1:0]      alloc_vc,
    output logic                         alloc_gnt,
    output logic [memory_addr_width-1:0] alloc_slot,
    input  logic                         free_valid,
    input  logic [vc_idx_width-1:0]      free_vc,
    input  logic [memory_addr_width-1:0] free_slot,
    output logic [num_vcs-1:0]           vc_can_alloc,
    output logic [count_width-1:0]       free_count,
    output logic                         memory_bank_full,
    output logic                         memory_bank_empty,
    output logic                         error_free
);

    // Index spaces rounded up to a power of two so any index value is addressable.
    localparam int vc_space   = 1 << vc_idx_width;
    localparam int slot_space = 1 << memory_addr_width;
    localparam logic [count_width-1:0] reserved_cnt = count_width'(reserved_per_vc);

    if (!reservation_ok(memory_bank_depth, num_vcs, reserved_per_vc)) begin : g_bad_cfg
        $error("reservations exceed memory_bank_depth");
    end

    logic [count_width-1:0] occ [num_vcs];
    logic [slot_space-1:0]  in_use;
    logic [count_width-1:0] deficit;
    logic [count_width-1:0] shared_avail;
    logic [vc_space-1:0]    can_padded;
    logic [vc_space-1:0]    occ_nz_padded;
    logic [num_vcs-1:0]     occ_nz;
    logic                   free_legal;
    logic [memory_addr_width-1:0] head_slot;

    shared_buffer_slot_allocator_free_slot_fifo #(
        .depth       (memory_bank_depth),
        .addr_width  (memory_addr_width),
        .count_width (count_width)
    ) u_free_slot_fifo (
        .clk       (clk),
        .reset     (reset),
        .pop       (alloc_gnt),
        .push      (free_legal),
        .push_slot (free_slot),
        .head_slot (head_slot),
        .count     (free_count)
    );

    // Unmet reservations across all VCs, and per-VC non-empty flags.
    always_comb begin
        deficit = '0;
        occ_nz  = '0;
        for (int v = 0; v < num_vcs; v++) begin
            if (occ[v] < reserved_cnt) begin
                deficit = deficit + (reserved_cnt - occ[v]);
            end
            occ_nz[v] = (occ[v] != '0);
        end
    end

    assign shared_avail = free_count - deficit;

    // A VC may allocate from its own reservation or from whatever the shared pool has left.
    always_comb begin
        vc_can_alloc = '0;
        for (int v = 0; v < num_vcs; v++) begin
            vc_can_alloc[v] = (free_count != '0) &&
                              ((occ[v] < reserved_cnt) || (shared_avail != '0));
        end
    end

    assign can_padded    = vc_space'(vc_can_alloc);
    assign occ_nz_padded = vc_space'(occ_nz);

    assign alloc_gnt  = alloc_req && can_padded[alloc_vc];
    assign alloc_slot = head_slot;

    // A slot granted this cycle is not yet in_use, so freeing it in the same cycle is rejected.
    assign free_legal = free_valid && in_use[free_slot] && occ_nz_padded[free_vc];

    // Per-VC occupancy; a grant and a legal free on the same VC cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < num_vcs; v++) begin
                occ[v] <= '0;
            end
        end else begin
            for (int v = 0; v < num_vcs; v++) begin
                if ((alloc_gnt && (alloc_vc == vc_idx_width'(v))) &&
                    !(free_legal && (free_vc == vc_idx_width'(v)))) begin
                    occ[v] <= occ[v] + 1'b1;
                end else if (!(alloc_gnt && (alloc_vc == vc_idx_width'(v))) &&
                             (free_legal && (free_vc == vc_idx_width'(v)))) begin
                    occ[v] <= occ[v] - 1'b1;
                end
            end
        end
    end

    // Slot ownership bitmap used to reject double frees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_use <= '0;
        end else begin
            if (free_legal) begin
                in_use[free_slot] <= 1'b0;
            end
            if (alloc_gnt) begin
                in_use[alloc_slot] <= 1'b1;
            end
        end
    end

    // Sticky flag for any rejected free; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_free <= 1'b0;
        end else if (free_valid && !free_legal) begin
            error_free <= 1'b1;
        end
    end

    assign memory_bank_full  = (free_count == '0);
    assign memory_bank_empty = (free_count == count_width'(memory_bank_depth));

endmodule

// File: tb/tb_shared_buffer_slot_allocator.sv
// Directed bench with a reference free-list model and a grant scoreboard.
module tb_shared_buffer_slot_allocator;

    localparam int DEPTH = 32;
    localparam int NV    = 4;
    localparam int RES   = 2;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic [1:0] alloc_vc;
    logic       alloc_gnt;
    logic [4:0] alloc_slot;
    logic       free_valid;
    logic [1:0] free_vc;
    logic [4:0] free_slot;
    logic [3:0] vc_can_alloc;
    logic [5:0] free_count;
    logic       memory_bank_full;
    logic       memory_bank_empty;
    logic       error_free;

    int checks   = 0;
    int failures = 0;

    int mfree[$];
    int exp_q[$];
    int mocc [NV];
    bit m_inuse [DEPTH];
    bit merr;

    shared_buffer_slot_allocator #(
        .memory_bank_depth (DEPTH),
        .num_vcs           (NV),
        .reserved_per_vc   (RES)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .alloc_req         (alloc_req),
        .alloc_vc          (alloc_vc),
        .alloc_gnt         (alloc_gnt),
        .alloc_slot        (alloc_slot),
        .free_valid        (free_valid),
        .free_vc           (free_vc),
        .free_slot         (free_slot),
        .vc_can_alloc      (vc_can_alloc),
        .free_count        (free_count),
        .memory_bank_full  (memory_bank_full),
        .memory_bank_empty (memory_bank_empty),
        .error_free        (error_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        mfree.delete();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            mfree.push_back(i);
            m_inuse[i] = 1'b0;
        end
        for (int v = 0; v < NV; v++) mocc[v] = 0;
        merr = 1'b0;
    endfunction

    function automatic bit m_can(input int v);
        int deficit;
        deficit = 0;
        for (int i = 0; i < NV; i++) begin
            if (mocc[i] < RES) deficit += RES - mocc[i];
        end
        return (mfree.size() > 0) && ((mocc[v] < RES) || ((mfree.size() - deficit) > 0));
    endfunction

    function automatic logic [3:0] m_can_vec();
        logic [3:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_can(v);
        return r;
    endfunction

    task automatic status_chk(input string tag);
        chk({tag, "_free_count"}, free_count, mfree.size());
        chk({tag, "_full"}, memory_bank_full, mfree.size() == 0);
        chk({tag, "_empty"}, memory_bank_empty, mfree.size() == DEPTH);
        chk({tag, "_vc_can"}, vc_can_alloc, m_can_vec());
        chk({tag, "_error"}, error_free, merr);
    endtask

    // One clock of stimulus; inputs change just after the rising edge.
    task automatic cycle(input bit req, input int avc, input bit fv, input int fvc, input int fslot);
        bit gx;
        bit lx;
        int gslot;
        int sx;
        alloc_req  = req;
        alloc_vc   = 2'(avc);
        free_valid = fv;
        free_vc    = 2'(fvc);
        free_slot  = 5'(fslot);
        gx = req && m_can(avc);
        lx = fv && m_inuse[fslot] && (mocc[fvc] > 0);
        gslot = (mfree.size() > 0) ? mfree[0] : 0;
        if (gx) exp_q.push_back(gslot);
        @(negedge clk);
        chk("alloc_gnt", alloc_gnt, gx);
        if (gx) begin
            sx = exp_q.pop_front();
            chk("alloc_slot", alloc_slot, sx);
        end
        status_chk("cyc");
        @(posedge clk);
        if (gx) begin
            void'(mfree.pop_front());
            mocc[avc]++;
            m_inuse[gslot] = 1'b1;
        end
        if (lx) begin
            mfree.push_back(fslot);
            mocc[fvc]--;
            m_inuse[fslot] = 1'b0;
        end else if (fv) begin
            merr = 1'b1;
        end
        #1;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        m_reset();
        chk("rst_free_count", free_count, 32);
        chk("rst_empty", memory_bank_empty, 1);
        chk("rst_full", memory_bank_full, 0);
        chk("rst_gnt", alloc_gnt, 0);
        chk("rst_vc_can", vc_can_alloc, 4'hf);
        chk("rst_error", error_free, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        alloc_req  = 1'b0;
        alloc_vc   = '0;
        free_valid = 1'b0;
        free_vc    = '0;
        free_slot  = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        status_chk("init");
        chk("init_gnt", alloc_gnt, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Five grants, then an asynchronous reset mid-run; allocation restarts at slot 0.
        for (int i = 0; i < 5; i++) cycle(1, i % NV, 0, 0, 0);
        pulse_reset();
        alloc_req = 1'b1;
        alloc_vc  = 2'd0;
        #1;
        chk("first_after_rst_slot", alloc_slot, 0);
        alloc_req = 1'b0;
        cycle(1, 0, 0, 0, 0);
        pulse_reset();

        // VC0 grabs everything but the other VCs' reservations.
        for (int i = 0; i < 27; i++) cycle(1, 0, 0, 0, 0);
        chk("res_vc_can", vc_can_alloc, 4'b1110);
        chk("res_free_count", free_count, 6);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 3, 0, 0, 0);
        cycle(1, 3, 0, 0, 0);
        chk("drain_full", memory_bank_full, 1);
        chk("drain_vc_can", vc_can_alloc, 4'b0000);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 3, 0, 0, 0);

        // Full: a same-cycle free cannot feed a grant; the slot appears next cycle.
        cycle(1, 1, 1, 0, 12);
        chk("fullb_count_after_free", free_count, 1);
        cycle(1, 1, 0, 0, 0);
        chk("fullb_full_again", memory_bank_full, 1);

        // Three free slots, then a free and a grant on VC2 together.
        cycle(0, 0, 1, 0, 20);
        cycle(0, 0, 1, 0, 21);
        cycle(0, 0, 1, 0, 22);
        chk("sim_pre_count", free_count, 3);
        cycle(1, 2, 1, 2, 7);
        chk("sim_post_count", free_count, 3);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        chk("sim_drained", free_count, 0);

        // Double free of slot 5: second one rejected, flag sticks.
        cycle(0, 0, 1, 0, 5);
        cycle(0, 0, 1, 0, 5);
        chk("dbl_error", error_free, 1);
        chk("dbl_count", free_count, 1);
        cycle(0, 0, 0, 0, 0);
        pulse_reset();

        // Free on a VC holding nothing, and freeing the slot being granted.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        chk("occ0_error", error_free, 1);
        chk("occ0_count", free_count, 31);
        cycle(1, 0, 1, 0, 1);
        chk("same_slot_count", free_count, 30);
        cycle(0, 0, 1, 0, 1);
        chk("late_free_count", free_count, 31);
        pulse_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
